ex_operand_stage: RTL
=====================

# ex_operand_stage

ID/EX pipeline register and operand-forwarding stage that sits directly upstream of the ALU. It captures a decoded instruction, resolves rs1/rs2 against in-flight MEM and WB results, and holds the ALU's SrcA, SrcB and Operation stable. It inserts bubbles on load-use hazards and supports flush, using a valid/ready handshake toward both decode and execute.

## Interface
- DATA_WIDTH, 32, operand/result width
- OPCODE_LENGTH, 4, ALU operation code width
- REG_ADDR_WIDTH, 5, register index width
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- flush  input  1  kill stored entry and any same-cycle ID transfer
- id_valid  input  1  decode presents an instruction
- id_ready  output  1  stage can accept this cycle
- id_rs1, id_rs2, id_rd  input  REG_ADDR_WIDTH each  register indices
- id_rs1_data, id_rs2_data  input  DATA_WIDTH each  register-file read data
- id_imm  input  DATA_WIDTH  sign-extended immediate
- id_alu_src  input  1  1: SrcB = immediate; 0: SrcB = rs2 operand
- id_alu_op  input  OPCODE_LENGTH  ALU operation code
- id_reg_write  input  1  instruction writes rd
- mem_fwd_valid, mem_fwd_rd, mem_fwd_data  input  1/REG_ADDR_WIDTH/DATA_WIDTH  EX/MEM result available for forwarding
- wb_fwd_valid, wb_fwd_rd, wb_fwd_data  input  1/REG_ADDR_WIDTH/DATA_WIDTH  register-file write this cycle
- ld_pending_valid, ld_pending_rd  input  1/REG_ADDR_WIDTH  load in MEM whose data is not yet available
- ex_valid  output  1  SrcA/SrcB/Operation are valid for the ALU
- ex_ready  input  1  execute consumes this cycle
- SrcA, SrcB  output  DATA_WIDTH each  ALU operands
- Operation  output  OPCODE_LENGTH  ALU operation
- ex_rd  output  REG_ADDR_WIDTH  destination index
- ex_reg_write  output  1  destination write enable
- stall_count  output  16  saturating count of load-use bubble cycles

## Operation
- Stored entry: valid_q, rs1_q, rs2_q, rd_q, a_q, b_q, imm_q, alu_src_q, op_q, reg_write_q.
- Match rule: a source index matches a producer only if the producer's valid is 1, its rd equals the source index, and the source index ≠ 0. Index 0 never forwards and never causes a hazard. a_q/b_q captured for index 0 are forced to 0.
- Capture: on a transfer (id_valid & id_ready), load all fields. a_q takes wb_fwd_data if WB matches id_rs1, else id_rs1_data. b_q uses the same rule for id_rs2.
- Hold refresh: while valid_q=1 and no transfer, a_q/b_q update to wb_fwd_data on a WB match. This keeps retiring results from being lost across stalls.
- Output forwarding (combinational): rsA = MEM match on rs1_q ? mem_fwd_data : WB match ? wb_fwd_data : a_q. MEM has priority over WB. rsB uses the same rule on rs2_q.
- SrcA = rsA. SrcB = alu_src_q ? imm_q : rsB.
- Hazard = valid_q & (ld_pending match on rs1_q | (ld_pending match on rs2_q & ~alu_src_q)).
- ex_valid = valid_q & ~hazard.
- id_ready = ~flush & (~valid_q | (ex_valid & ex_ready)).
- Next valid_q:
  - flush → 0.
  - else transfer → 1.
  - else ex_valid & ex_ready → 0.
  - else hold.
- Bubble outputs: when valid_q=0, Operation=0, ex_rd=0 and ex_reg_write=0. SrcA/SrcB are don't-care but must be deterministic.
- stall_count increments on each cycle with valid_q & hazard, saturating at 16'hFFFF. It is not cleared by flush.

## Timing
- Reset: valid_q=0, all stored fields 0, stall_count=0. Consequently ex_valid=0, id_ready=1, SrcA=SrcB=0, Operation=0, ex_rd=0, ex_reg_write=0.
- Latency: one cycle from ID transfer to ex_valid, absent hazard. Full throughput is one instruction per cycle when ex_ready=1.
- Forwarding paths are combinational and visible in the same cycle the producer asserts its valid.
- A hazard clears in the cycle ld_pending_valid drops or its rd changes. ex_valid rises in that same cycle.
- Reset and flush asserted mid-hold discard the entry with no ALU issue. Reset has priority over flush.
- A simultaneous drain and transfer replaces the entry with no bubble.

## Test plan
- Back-to-back transfer: ADD x3=x1+x2 with rs data 5/7, ex_ready=1, followed by a second instruction → ex_valid one cycle later with SrcA=5, SrcB=7, Operation=4'b0010. The next instruction issues on the following cycle with no bubble.
- MEM priority: rs1=4 with mem_fwd_rd=4 data 0xAA and wb_fwd_rd=4 data 0xBB in the same cycle → SrcA=0xAA.
- Load-use: ld_pending_rd=2 with entry rs2=2, alu_src=0 → ex_valid=0 and id_ready=0 for 2 cycles, stall_count=2. Release with wb_fwd_rd=2 data 0x1234 → SrcB=0x1234. With alu_src=1 instead, there is no stall.
- Stall refresh: ex_ready=0 for 3 cycles while WB writes x1=0x55 once → after release, SrcA=0x55 although wb_fwd_valid is now 0.
- x0: rs1=0 with mem_fwd_rd=0 data 0xFF → SrcA=0. ld_pending_rd=0 → no stall.
- Flush: flush asserted during a hold together with id_valid=1 → next cycle valid_q=0, id_ready=1, Operation=0. The flushed instruction never shows ex_valid.

Source files
------------

// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register with operand forwarding ahead of the ALU.
// Holds one decoded instruction, resolves rs1/rs2 against MEM and WB
// producers, and inserts bubbles while a load result is still outstanding.
module ex_operand_stage #(
  parameter int DATA_WIDTH     = 32,
  parameter int OPCODE_LENGTH  = 4,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush,
  input  logic                      id_valid,
  output logic                      id_ready,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs1,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs2,
  input  logic [REG_ADDR_WIDTH-1:0] id_rd,
  input  logic [DATA_WIDTH-1:0]     id_rs1_data,
  input  logic [DATA_WIDTH-1:0]     id_rs2_data,
  input  logic [DATA_WIDTH-1:0]     id_imm,
  input  logic                      id_alu_src,
  input  logic [OPCODE_LENGTH-1:0]  id_alu_op,
  input  logic                      id_reg_write,
  input  logic                      mem_fwd_valid,
  input  logic [REG_ADDR_WIDTH-1:0] mem_fwd_rd,
  input  logic [DATA_WIDTH-1:0]     mem_fwd_data,
  input  logic                      wb_fwd_valid,
  input  logic [REG_ADDR_WIDTH-1:0] wb_fwd_rd,
  input  logic [DATA_WIDTH-1:0]     wb_fwd_data,
  input  logic                      ld_pending_valid,
  input  logic [REG_ADDR_WIDTH-1:0] ld_pending_rd,
  output logic                      ex_valid,
  input  logic                      ex_ready,
  output logic [DATA_WIDTH-1:0]     SrcA,
  output logic [DATA_WIDTH-1:0]     SrcB,
  output logic [OPCODE_LENGTH-1:0]  Operation,
  output logic [REG_ADDR_WIDTH-1:0] ex_rd,
  output logic                      ex_reg_write,
  output logic [15:0]               stall_count
);

  // Register x0 is hardwired to zero, so it never matches a producer.
  function automatic logic src_match(input logic                      v,
                                     input logic [REG_ADDR_WIDTH-1:0] rd,
                                     input logic [REG_ADDR_WIDTH-1:0] src);
    return v && (rd == src) && (src != '0);
  endfunction

  logic                      valid_q;
  logic [REG_ADDR_WIDTH-1:0] rs1_q, rs2_q, rd_q;
  logic [DATA_WIDTH-1:0]     a_q, b_q, imm_q;
  logic                      alu_src_q;
  logic [OPCODE_LENGTH-1:0]  op_q;
  logic                      reg_write_q;
  logic [15:0]               stall_q;

  logic                      transfer, fire, hazard;
  logic [DATA_WIDTH-1:0]     rs_a, rs_b, cap_a, cap_b;

  assign hazard   = valid_q & (src_match(ld_pending_valid, ld_pending_rd, rs1_q) |
                               (src_match(ld_pending_valid, ld_pending_rd, rs2_q) & ~alu_src_q));
  assign ex_valid = valid_q & ~hazard;
  assign fire     = ex_valid & ex_ready;
  assign id_ready = ~flush & (~valid_q | fire);
  assign transfer = id_valid & id_ready;

  // Operand resolution for the held entry: MEM is younger than WB, so it wins.
  always_comb begin
    rs_a = a_q;
    rs_b = b_q;
    if (src_match(wb_fwd_valid, wb_fwd_rd, rs1_q))   rs_a = wb_fwd_data;
    if (src_match(mem_fwd_valid, mem_fwd_rd, rs1_q)) rs_a = mem_fwd_data;
    if (src_match(wb_fwd_valid, wb_fwd_rd, rs2_q))   rs_b = wb_fwd_data;
    if (src_match(mem_fwd_valid, mem_fwd_rd, rs2_q)) rs_b = mem_fwd_data;
  end

  // Capture values: a same-cycle register-file write beats the stale read data.
  always_comb begin
    cap_a = (id_rs1 == '0) ? '0 : id_rs1_data;
    cap_b = (id_rs2 == '0) ? '0 : id_rs2_data;
    if (src_match(wb_fwd_valid, wb_fwd_rd, id_rs1)) cap_a = wb_fwd_data;
    if (src_match(wb_fwd_valid, wb_fwd_rd, id_rs2)) cap_b = wb_fwd_data;
  end

  // Bubbles present all-zero controls and operands so the ALU sees a quiet input.
  assign SrcA         = valid_q ? rs_a : '0;
  assign SrcB         = valid_q ? (alu_src_q ? imm_q : rs_b) : '0;
  assign Operation    = valid_q ? op_q : '0;
  assign ex_rd        = valid_q ? rd_q : '0;
  assign ex_reg_write = valid_q & reg_write_q;
  assign stall_count  = stall_q;

  // Entry occupancy: flush kills, transfer refills, a consumed entry drains.
  always_ff @(posedge clk) begin
    if (reset)         valid_q <= 1'b0;
    else if (flush)    valid_q <= 1'b0;
    else if (transfer) valid_q <= 1'b1;
    else if (fire)     valid_q <= 1'b0;
  end

  // Entry payload: load on transfer, otherwise track WB writes to held sources.
  always_ff @(posedge clk) begin
    if (reset) begin
      rs1_q       <= '0;
      rs2_q       <= '0;
      rd_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      imm_q       <= '0;
      alu_src_q   <= 1'b0;
      op_q        <= '0;
      reg_write_q <= 1'b0;
    end else if (transfer) begin
      rs1_q       <= id_rs1;
      rs2_q       <= id_rs2;
      rd_q        <= id_rd;
      a_q         <= cap_a;
      b_q         <= cap_b;
      imm_q       <= id_imm;
      alu_src_q   <= id_alu_src;
      op_q        <= id_alu_op;
      reg_write_q <= id_reg_write;
    end else if (valid_q) begin
      if (src_match(wb_fwd_valid, wb_fwd_rd, rs1_q)) a_q <= wb_fwd_data;
      if (src_match(wb_fwd_valid, wb_fwd_rd, rs2_q)) b_q <= wb_fwd_data;
    end
  end

  // Load-use bubble counter, saturating; survives flush.
  always_ff @(posedge clk) begin
    if (reset)                           stall_q <= '0;
    else if (hazard && stall_q != 16'hFFFF) stall_q <= stall_q + 16'd1;
  end

endmodule
